// File: rtl/wb_ps2_keyboard_if.sv
// wb_ps2_keyboard_if: Wishbone slave-slot bundle between the intercon and the keyboard receiver
interface wb_ps2_keyboard_if;
   logic        STB;
   logic        WE;
   logic [31:0] ADDR;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK;
   modport master (output STB, WE, ADDR, DAT_I, input DAT_O, ACK);
   modport slave (input STB, WE, ADDR, DAT_I, output DAT_O, ACK);
endinterface

// File: rtl/wb_ps2_keyboard.sv
// wb_ps2_keyboard: PS/2 keyboard frame receiver with a scan-code FIFO behind a Wishbone slave
module wb_ps2_keyboard #(
   parameter int FIFO_AW    = 4,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   wb_ps2_keyboard_if.slave   bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FIFO_AW:0] PTR_ONE = 1;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state_q, state_d;
   logic [1:0] ck_sync_q, ck_sync_d, dt_sync_q, dt_sync_d;
   logic [FILTER_LEN-1:0] filt_q, filt_d;
   logic fclk_q, fclk_d, fall, bit_in;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d;
   logic par_q, par_d;
   logic [TW-1:0] to_q, to_d;
   logic timeout, good_par, push, pe_set, fe_set;
   logic [FIFO_AW:0] wp_q, wp_d, rp_q, rp_d;
   logic [7:0] mem_q [2**FIFO_AW];
   logic empty, full, acc, pop, wr_en, ovf_set, clr;
   logic ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d, ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic unused_bits;
   assign unused_bits = ^{bus.ADDR[31:3], bus.ADDR[1:0], bus.DAT_I[31:5], bus.DAT_I[1:0]};
   // Synchronise both lines and debounce the clock; a fall is the filtered clock dropping
   always_comb begin
      ck_sync_d = {ck_sync_q[0], ps2_clk};
      dt_sync_d = {dt_sync_q[0], ps2_data};
      filt_d    = {filt_q[FILTER_LEN-2:0], ck_sync_q[1]};
      fclk_d    = &filt_q ? 1'b1 : ~|filt_q ? 1'b0 : fclk_q;
      fall      = fclk_q & ~fclk_d;
      bit_in    = dt_sync_q[1];
   end
   // Frame datapath: bit counter, LSB-first shifter, parity latch and mid-frame idle counter
   always_comb begin
      cnt_d   = (fall && state_q == IDLE) ? 3'd0 : (fall && state_q == DATA) ? cnt_q + 3'd1 : cnt_q;
      sh_d    = (fall && state_q == DATA) ? {bit_in, sh_q[7:1]} : sh_q;
      par_d   = (fall && state_q == PARITY) ? bit_in : par_q;
      to_d    = (state_q == IDLE || fall) ? '0 : to_q + TW'(1);
      timeout = state_q != IDLE && !fall && to_q == TW'(TIMEOUT);
   end
   // Receive FSM next state; a stalled frame falls back to IDLE without flagging anything
   always_comb begin
      state_d = state_q;
      if (timeout) state_d = IDLE;
      else if (fall)
         case (state_q)
            IDLE:    state_d = bit_in ? IDLE : DATA;
            DATA:    state_d = cnt_q == 3'd7 ? PARITY : DATA;
            PARITY:  state_d = STOP;
            default: state_d = IDLE;
         endcase
   end
   // Receive FSM outputs: judge the frame on the stop-bit fall
   always_comb begin
      good_par = ^{sh_q, par_q};
      push     = fall && state_q == STOP && bit_in && good_par;
      pe_set   = fall && state_q == STOP && !good_par;
      fe_set   = fall && state_q == STOP && good_par && !bit_in;
   end
   // FIFO control, sticky flags and the one-access-per-ACK bus side
   always_comb begin
      empty   = wp_q == rp_q;
      full    = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) && (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
      acc     = bus.STB & ~ack_q;
      pop     = acc & ~bus.WE & ~bus.ADDR[2] & ~empty;
      wr_en   = push & (~full | pop);
      ovf_set = push & full & ~pop;
      clr     = acc & bus.WE & bus.ADDR[2];
      wp_d    = wr_en ? wp_q + PTR_ONE : wp_q;
      rp_d    = pop ? rp_q + PTR_ONE : rp_q;
      ovf_d   = ovf_set | (ovf_q & ~(clr & bus.DAT_I[2]));
      perr_d  = pe_set | (perr_q & ~(clr & bus.DAT_I[3]));
      ferr_d  = fe_set | (ferr_q & ~(clr & bus.DAT_I[4]));
      ack_d   = acc;
      dat_d   = !(acc & ~bus.WE) ? dat_q :
                bus.ADDR[2] ? {27'b0, ferr_q, perr_q, ovf_q, full, ~empty} :
                empty ? 32'b0 : {23'b0, 1'b1, mem_q[rp_q[FIFO_AW-1:0]]};
   end
   // FSM state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= IDLE;
      else state_q <= state_d;
   // Datapath, pointer, flag and bus registers; lines reset to idle-high
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ck_sync_q <= '1;
         dt_sync_q <= '1;
         filt_q    <= '1;
         fclk_q    <= 1'b1;
         cnt_q     <= '0;
         sh_q      <= '0;
         par_q     <= 1'b0;
         to_q      <= '0;
         wp_q      <= '0;
         rp_q      <= '0;
         ovf_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         ck_sync_q <= ck_sync_d;
         dt_sync_q <= dt_sync_d;
         filt_q    <= filt_d;
         fclk_q    <= fclk_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         par_q     <= par_d;
         to_q      <= to_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         ovf_q     <= ovf_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   // FIFO storage needs no reset: the pointers define what is valid
   always_ff @(posedge clk)
      if (wr_en) mem_q[wp_q[FIFO_AW-1:0]] <= sh_q;
   assign bus.ACK   = ack_q;
   assign bus.DAT_O = dat_q;
endmodule

// File: tb/tb_wb_ps2_keyboard.sv
// tb_wb_ps2_keyboard: frame-level keyboard model and bus reads checked against a queue reference
module tb_wb_ps2_keyboard;
   localparam int HALF = 20;
   localparam int TO   = 1000;
   logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1;
   int errors = 0, checks = 0;
   byte unsigned q[$];
   bit m_ovf, m_par, m_frm;
   logic [31:0] rd, exp;
   bit ok;
   wb_ps2_keyboard_if bus();
   wb_ps2_keyboard #(.FIFO_AW(4), .FILTER_LEN(8), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] exp_status();
      return {27'b0, m_frm, m_par, m_ovf, q.size() == 16, q.size() != 0};
   endfunction
   function automatic logic [31:0] exp_data();
      if (q.size() == 0) return 32'h0;
      return {23'b0, 1'b1, q.pop_front()};
   endfunction
   function automatic logic [10:0] frame(input logic [7:0] b, input bit bp, input bit bs);
      return {~bs, ~(^b) ^ bp, b, 1'b0};
   endfunction
   task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs);
      if (bp) m_par = 1;
      else if (bs) m_frm = 1;
      else if (q.size() == 16) m_ovf = 1;
      else q.push_back(b);
   endtask
   task automatic ps2_bits(input logic [10:0] f, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ps2_data = f[i];
         wait_cyc(HALF);
         ps2_clk = 0;
         wait_cyc(HALF);
         ps2_clk = 1;
      end
      wait_cyc(HALF);
      ps2_data = 1;
      wait_cyc(HALF);
   endtask
   task automatic send(input logic [7:0] b, input bit bp, input bit bs);
      ps2_bits(frame(b, bp, bs), 0, 10);
      model_frame(b, bp, bs);
   endtask
   task automatic wb_cycle(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output bit acked);
      bus.STB = 1; bus.WE = we; bus.ADDR = addr; bus.DAT_I = wd; acked = 0;
      for (int i = 0; i < 4 && !acked; i++) begin
         wait_cyc(1);
         acked = bus.ACK;
      end
      rdata = bus.DAT_O;
      bus.STB = 0; bus.WE = 0;
      wait_cyc(1);
   endtask
   task automatic test_reset();
      #2 reset = 0;
      wait_cyc(3);
      checks++;
      if (bus.ACK !== 1'b0 || bus.DAT_O !== 32'h0) begin
         errors++; $display("FAIL reset_outputs: ack=%b dat=%h required ack=0 dat=0", bus.ACK, bus.DAT_O);
      end
      reset = 1;
      wait_cyc(2);
      wb_cycle(0, 32'h4, 0, rd, ok); checks++;
      if (!ok || rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0 ack=%0b", rd, ok); end
   endtask
   task automatic test_good_frame();
      send(8'h1C, 0, 0);
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL good_status: got %h want %h", rd, exp); end
      wb_cycle(0, 32'h0, 0, rd, ok); exp = exp_data(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL good_data: got %h want %h", rd, exp); end
      wb_cycle(0, 32'h0, 0, rd, ok); exp = exp_data(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL good_empty_read: got %h want %h", rd, exp); end
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL good_status_after: got %h want %h", rd, exp); end
   endtask
   task automatic test_parity();
      send(8'hF0, 1, 0);
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL parity_status: got %h want %h", rd, exp); end
      wb_cycle(1, 32'h4, 32'h8, rd, ok); m_par = 0; checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL write_holds_dat: got %h want %h", rd, exp); end
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL parity_cleared: got %h want %h", rd, exp); end
   endtask
   task automatic test_overflow();
      for (int i = 0; i < 17; i++) send(8'(i), 0, 0);
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL ovf_status: got %h want %h", rd, exp); end
      for (int i = 0; i < 17; i++) begin
         wb_cycle(0, 32'h0, 0, rd, ok); exp = exp_data(); checks++;
         if (!ok || rd !== exp) begin errors++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, rd, exp); end
      end
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL ovf_sticky: got %h want %h", rd, exp); end
      wb_cycle(1, 32'h4, 32'h4, rd, ok); m_ovf = 0;
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL ovf_cleared: got %h want %h", rd, exp); end
   endtask
   task automatic test_glitch_timeout();
      ps2_data = 0; ps2_clk = 0;
      wait_cyc(3);
      ps2_clk = 1;
      wait_cyc(2);
      ps2_data = 1;
      wait_cyc(HALF);
      send(8'h3C, 0, 0);
      wb_cycle(0, 32'h0, 0, rd, ok); exp = exp_data(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL glitch_data: got %h want %h", rd, exp); end
      ps2_bits(frame(8'hA5, 0, 0), 0, 4);
      wait_cyc(TO + 10);
      send(8'h5A, 0, 0);
      wb_cycle(0, 32'h0, 0, rd, ok); exp = exp_data(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL timeout_data: got %h want %h", rd, exp); end
      wb_cycle(0, 32'h0, 0, rd, ok); exp = exp_data(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL timeout_only_one: got %h want %h", rd, exp); end
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL timeout_flags: got %h want %h", rd, exp); end
   endtask
   task automatic test_reset_midframe();
      send(8'h77, 0, 0);
      wb_cycle(0, 32'h4, 0, rd, ok);
      ps2_bits(frame(8'hE1, 0, 0), 0, 5);
      #3 reset = 0;
      #1 checks++;
      if (bus.ACK !== 1'b0 || bus.DAT_O !== 32'h0) begin
         errors++; $display("FAIL async_reset: ack=%b dat=%h required ack=0 dat=0", bus.ACK, bus.DAT_O);
      end
      q.delete(); m_ovf = 0; m_par = 0; m_frm = 0;
      wait_cyc(3);
      reset = 1;
      wait_cyc(2);
      ps2_bits(frame(8'hE1, 0, 0), 6, 10);
      send(8'h29, 0, 0);
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL midreset_status: got %h want %h", rd, exp); end
   endtask
   task automatic test_back_to_back();
      bus.STB = 1; bus.WE = 0; bus.ADDR = 32'h0;
      for (int c = 1; c <= 4; c++) begin
         wait_cyc(1); checks++;
         if (bus.ACK !== c[0]) begin errors++; $display("FAIL held_stb_ack[%0d]: got %b want %b", c, bus.ACK, c[0]); end
         if (c[0]) begin
            exp = exp_data(); checks++;
            if (bus.DAT_O !== exp) begin errors++; $display("FAIL held_stb_dat[%0d]: got %h want %h", c, bus.DAT_O, exp); end
         end
      end
      bus.STB = 0;
      wait_cyc(1);
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL held_stb_status: got %h want %h", rd, exp); end
   endtask
   task automatic test_random();
      int r;
      logic [31:0] w;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6) send(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 1);
         else if (r < 8) begin
            wb_cycle(0, 32'h0, 0, rd, ok); exp = exp_data(); checks++;
            if (!ok || rd !== exp) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, rd, exp); end
         end else if (r == 8) begin
            wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
            if (!ok || rd !== exp) begin errors++; $display("FAIL rand_status[%0d]: got %h want %h", n, rd, exp); end
         end else begin
            w = $urandom;
            wb_cycle(1, {29'b0, w[31], 2'b0}, w, rd, ok);
            if (w[31]) begin
               if (w[2]) m_ovf = 0;
               if (w[3]) m_par = 0;
               if (w[4]) m_frm = 0;
            end
         end
      end
      wb_cycle(0, 32'h4, 0, rd, ok); exp = exp_status(); checks++;
      if (!ok || rd !== exp) begin errors++; $display("FAIL rand_final_status: got %h want %h", rd, exp); end
   endtask
   initial begin
      bus.STB = 0; bus.WE = 0; bus.ADDR = 0; bus.DAT_I = 0;
      test_reset();
      test_good_frame();
      test_parity();
      test_overflow();
      test_glitch_timeout();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
